// File: rtl/image_ram_loader_if.sv
// Byte-stream valid/ready channel feeding the image RAM loader.
interface image_ram_loader_if #(
  parameter int RAM_WIDTH = 8
) ();
  logic [RAM_WIDTH-1:0] data;
  logic                 valid;
  logic                 ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/image_ram_loader.sv
// Fills an image RAM sequentially from a valid/ready byte stream and exposes a registered read port.
// Optional running XOR checksum output enabled by defining IMAGE_RAM_LOADER_CHECKSUM_EN.
module image_ram_loader #(
  parameter int RAM_WIDTH     = 8,
  parameter int RAM_ADDR_BITS = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  image_ram_loader_if.slave        s_in,
  input  logic                     i_start,
  input  logic [RAM_ADDR_BITS-1:0] i_rd_addr,
  output logic [RAM_WIDTH-1:0]     o_rd_data,
  output logic [RAM_ADDR_BITS:0]   o_wr_count,
  output logic                     o_busy,
  output logic                     o_done,
`ifdef IMAGE_RAM_LOADER_CHECKSUM_EN
  output logic [RAM_WIDTH-1:0]     o_checksum,
`endif
  output logic                     o_overflow
);

  localparam int DEPTH = 2 ** RAM_ADDR_BITS;
  localparam logic [RAM_ADDR_BITS-1:0] PTR_ONE = 1;
  localparam logic [RAM_ADDR_BITS:0]   CNT_ONE = 1;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE} state_t;

  state_t                     r_state;
  state_t                     w_state_next;
  logic [RAM_ADDR_BITS-1:0]   r_wr_ptr;
  logic [RAM_ADDR_BITS:0]     r_wr_count;
  logic                       r_overflow;
  logic [RAM_WIDTH-1:0]       r_rd_data;
  logic [RAM_WIDTH-1:0]       r_mem [DEPTH];
  logic                       w_ready;
  logic                       w_busy;
  logic                       w_done;
  logic                       w_wr_en;
  logic                       w_last;

  // A start pulse takes priority over a simultaneous transfer: the word is dropped.
  assign w_wr_en = w_ready & s_in.valid & ~i_start;
  assign w_last  = &r_wr_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) w_state_next = ST_LOAD;
      end
      ST_LOAD: begin
        w_ready = 1'b1;
        w_busy  = 1'b1;
        if (!i_start && w_wr_en && w_last) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        w_done = 1'b1;
        if (i_start) w_state_next = ST_LOAD;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_wr_count <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (i_start) begin
        r_wr_ptr   <= '0;
        r_wr_count <= '0;
        r_overflow <= 1'b0;
      end else begin
        if (w_wr_en) begin
          r_wr_ptr   <= r_wr_ptr + PTR_ONE;
          r_wr_count <= r_wr_count + CNT_ONE;
        end
        if (r_state == ST_DONE && s_in.valid) r_overflow <= 1'b1;
      end
    end
  end

  // RAM array is never reset so it maps onto block RAM; nonblocking read gives read-before-write.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= s_in.data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_rd_data <= '0;
    else        r_rd_data <= r_mem[i_rd_addr];
  end

`ifdef IMAGE_RAM_LOADER_CHECKSUM_EN
  logic [RAM_WIDTH-1:0] r_checksum;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       r_checksum <= '0;
    else if (i_start) r_checksum <= '0;
    else if (w_wr_en) r_checksum <= r_checksum ^ s_in.data;
  end

  assign o_checksum = r_checksum;
`endif

  assign s_in.ready = w_ready;
  assign o_busy     = w_busy;
  assign o_done     = w_done;
  assign o_rd_data  = r_rd_data;
  assign o_wr_count = r_wr_count;
  assign o_overflow = r_overflow;

endmodule

// File: tb/tb_image_ram_loader.sv
// Directed self-checking bench for image_ram_loader (checksum checks follow IMAGE_RAM_LOADER_CHECKSUM_EN).
module tb_image_ram_loader;

  localparam int RAM_WIDTH     = 8;
  localparam int RAM_ADDR_BITS = 3;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     start;
  logic [RAM_ADDR_BITS-1:0] rd_addr;
  logic [RAM_WIDTH-1:0]     rd_data;
  logic [RAM_ADDR_BITS:0]   wr_count;
  logic                     busy;
  logic                     done;
  logic                     overflow;
`ifdef IMAGE_RAM_LOADER_CHECKSUM_EN
  logic [RAM_WIDTH-1:0]     checksum;
`endif

  int n_checks = 0;
  int n_errors = 0;

  image_ram_loader_if #(.RAM_WIDTH(RAM_WIDTH)) stream ();

  image_ram_loader #(
    .RAM_WIDTH     (RAM_WIDTH),
    .RAM_ADDR_BITS (RAM_ADDR_BITS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .s_in       (stream.slave),
    .i_start    (start),
    .i_rd_addr  (rd_addr),
    .o_rd_data  (rd_data),
    .o_wr_count (wr_count),
    .o_busy     (busy),
    .o_done     (done),
`ifdef IMAGE_RAM_LOADER_CHECKSUM_EN
    .o_checksum (checksum),
`endif
    .o_overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    stream.data  = d;
    stream.valid = 1'b1;
    step();
    stream.valid = 1'b0;
  endtask

  task automatic read_expect(input string tag, input int addr, input logic [7:0] exp);
    rd_addr = 3'(addr);
    step();
    chk(tag, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    reset        = 1'b0;
    start        = 1'b0;
    rd_addr      = '0;
    stream.data  = '0;
    stream.valid = 1'b0;
    #2;
    chk("rst_rd_data", 32'(rd_data), 32'h0);
    chk("rst_wr_count", 32'(wr_count), 32'h0);
    chk("rst_ready", 32'(stream.ready), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    step();
    reset = 1'b1;
    step();

    // Idle ignores valid data
    push(8'hEE);
    chk("idle_wr_count", 32'(wr_count), 32'h0);
    chk("idle_busy", 32'(busy), 32'h0);

    // Full load 01..08 with valid held high
    do_start();
    chk("load_busy", 32'(busy), 32'h1);
    chk("load_wr_count0", 32'(wr_count), 32'h0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("load_ready_%0d", i), 32'(stream.ready), 32'h1);
      stream.data  = 8'(i + 1);
      stream.valid = 1'b1;
      step();
    end
    stream.valid = 1'b0;
    chk("full_ready", 32'(stream.ready), 32'h0);
    chk("full_done", 32'(done), 32'h1);
    chk("full_busy", 32'(busy), 32'h0);
    chk("full_wr_count", 32'(wr_count), 32'h8);
    chk("full_overflow", 32'(overflow), 32'h0);
`ifdef IMAGE_RAM_LOADER_CHECKSUM_EN
    chk("full_checksum", 32'(checksum), 32'h08);
`endif
    for (int a = 0; a < 8; a++)
      read_expect($sformatf("full_rd_%0d", a), a, 8'(a + 1));

    // Overflow in DONE
    push(8'hFF);
    chk("ovf_set", 32'(overflow), 32'h1);
    step();
    chk("ovf_sticky", 32'(overflow), 32'h1);
    chk("ovf_done", 32'(done), 32'h1);
    read_expect("ovf_rd_0", 0, 8'h01);
    read_expect("ovf_rd_7", 7, 8'h08);
    do_start();
    chk("ovf_cleared", 32'(overflow), 32'h0);
    chk("restart_busy", 32'(busy), 32'h1);

    // Toggle valid every other cycle with A0..A7
    for (int i = 0; i < 15; i++) begin
      stream.valid = (i % 2 == 0);
      stream.data  = 8'(8'hA0 + i / 2);
      step();
      if (i == 13) begin
        chk("tog_done_early", 32'(done), 32'h0);
        chk("tog_count7", 32'(wr_count), 32'h7);
      end
      if (i == 14) begin
        stream.valid = 1'b0;
        chk("tog_done", 32'(done), 32'h1);
        chk("tog_count8", 32'(wr_count), 32'h8);
      end
    end
`ifdef IMAGE_RAM_LOADER_CHECKSUM_EN
    chk("tog_checksum", 32'(checksum), 32'h00);
`endif
    for (int a = 0; a < 8; a++)
      read_expect($sformatf("tog_rd_%0d", a), a, 8'(8'hA0 + a));

    // Start collides with a transfer after 3 words
    do_start();
    push(8'h31);
    push(8'h32);
    push(8'h33);
    chk("col_count3", 32'(wr_count), 32'h3);
    start        = 1'b1;
    stream.valid = 1'b1;
    stream.data  = 8'h55;
    step();
    start        = 1'b0;
    stream.valid = 1'b0;
    chk("col_count0", 32'(wr_count), 32'h0);
    chk("col_busy", 32'(busy), 32'h1);
`ifdef IMAGE_RAM_LOADER_CHECKSUM_EN
    chk("col_checksum", 32'(checksum), 32'h00);
`endif
    read_expect("col_rd_0_old", 0, 8'h31);
    push(8'h77);
    chk("col_count1", 32'(wr_count), 32'h1);
    read_expect("col_rd_0_new", 0, 8'h77);
    read_expect("col_rd_1_old", 1, 8'h32);

    // Read-before-write at address 2
    do_start();
    push(8'h00);
    push(8'h00);
    push(8'h11);
    do_start();
    push(8'hE0);
    push(8'hE1);
    rd_addr      = 3'd2;
    stream.data  = 8'h22;
    stream.valid = 1'b1;
    step();
    stream.valid = 1'b0;
    chk("rbw_old", 32'(rd_data), 32'h11);
    step();
    chk("rbw_new", 32'(rd_data), 32'h22);

    // Asynchronous reset mid-load after 5 words
    do_start();
    rd_addr = 3'd0;
    for (int i = 0; i < 5; i++) push(8'(8'hC0 + i));
    chk("ar_count5", 32'(wr_count), 32'h5);
    chk("ar_rd_pre", 32'(rd_data), 32'hC0);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_rd_data", 32'(rd_data), 32'h0);
    chk("ar_wr_count", 32'(wr_count), 32'h0);
    chk("ar_busy", 32'(busy), 32'h0);
    chk("ar_ready", 32'(stream.ready), 32'h0);
    chk("ar_done", 32'(done), 32'h0);
`ifdef IMAGE_RAM_LOADER_CHECKSUM_EN
    chk("ar_checksum", 32'(checksum), 32'h00);
`endif
    step();
    reset = 1'b1;
    step();
    chk("ar_idle_busy", 32'(busy), 32'h0);
    for (int a = 0; a < 5; a++)
      read_expect($sformatf("ar_rd_%0d", a), a, 8'(8'hC0 + a));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/image_ram_loader.md
Name: image_ram_loader

Overview:
- Write-side companion to the image RAM read/display path.
- Accepts a byte stream over a valid/ready handshake and fills an internal image RAM sequentially from address 0.
- Once full, signals done.
- Provides a registered random-access read port that the seven-segment display mux path reads at any time.

Parameters:
RAM_WIDTH, 8, data width of each image word and of the input stream
RAM_ADDR_BITS, 3, address width; depth = 2**RAM_ADDR_BITS (default 8 words)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
start  input  1  one-cycle pulse: clear write pointer/status, begin a load
in_data  input  RAM_WIDTH  stream data word
in_valid  input  1  in_data valid
in_ready  output  1  loader can accept a word this cycle
rd_addr  input  RAM_ADDR_BITS  read address
rd_data  output  RAM_WIDTH  registered read data
wr_count  output  RAM_ADDR_BITS+1  words written since last start (0..depth)
busy  output  1  high in LOAD state
done  output  1  high in DONE state
overflow  output  1  sticky: in_valid seen while in DONE

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; wr_ptr=0, wr_count=0, rd_data=0; in_ready=0, busy=0, done=0, overflow=0.
  - RAM contents are not reset.
- FSM states: IDLE, LOAD, DONE; in_ready, busy and done decode combinationally from state.
- IDLE:
  - in_ready=0; in_valid ignored.
  - start -> LOAD with wr_ptr=0, wr_count=0, overflow=0.
- LOAD:
  - in_ready=1.
  - Transfer occurs when in_valid & in_ready at a rising edge: mem[wr_ptr] <= in_data; wr_ptr++; wr_count++.
  - Transfer at wr_ptr = depth-1: next state DONE, wr_count=depth, wr_ptr wraps to 0.
- DONE:
  - in_ready=0; done=1 until next start.
  - in_valid=1 in any DONE cycle sets overflow (sticky); data dropped, RAM unchanged.
  - start -> LOAD, clearing wr_ptr, wr_count and overflow.
- start in LOAD:
  - Restarts the load: wr_ptr=0, wr_count=0, state stays LOAD.
  - Previously written words remain in RAM until overwritten.
- start and transfer in the same cycle: start wins; that word is not written, wr_count=0 next cycle.
- Read port:
  - rd_data <= mem[rd_addr] every cycle, in every state; latency 1 cycle.
  - Read and write to the same address in the same cycle: rd_data returns the old contents (read-before-write).
- Width rules:
  - wr_ptr is RAM_ADDR_BITS wide, wrapping naturally.
  - wr_count is one bit wider so depth is representable.
- Reset asserted mid-load: immediate return to IDLE; partial RAM contents retained, wr_count=0.

Optional Feature:
- Macro: IMAGE_RAM_LOADER_CHECKSUM_EN.
- When defined:
  - Adds output port checksum [RAM_WIDTH-1:0] = XOR of all words accepted since the last start.
  - Updated on the same edge as the RAM write; cleared to 0 on reset and on start.
  - Holds its value in DONE and IDLE.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then start, then stream 8'h01..8'h08 with in_valid held high -> in_ready high for exactly 8 cycles; done=1, wr_count=8; reading addr 0..7 returns 01..08 one cycle after each address; checksum (if enabled) = 8'h08.
- In LOAD, toggle in_valid every other cycle with words 8'hA0..8'hA7 -> only valid cycles are written; done after 8 accepted words, not after 8 cycles.
- In DONE, pulse in_valid with 8'hFF -> overflow=1 and stays 1; mem unchanged; next start clears overflow.
- After 3 words are written, assert start together with in_valid=1, in_data=8'h55 -> wr_count=0 next cycle; addr 0 still holds the old word; the next accepted word lands at addr 0.
- rd_addr=2 while writing addr 2 (old 8'h11, new 8'h22) -> rd_data=8'h11 next cycle, 8'h22 the cycle after.
- Drop reset to 0 asynchronously mid-load after 5 words -> outputs zero immediately without a clock edge; after release, addr 0..4 still read the loaded words.
